demux_buf: RTL and testbench
============================

Name: demux_buf

Overview:
- 1:2 buffered demultiplexer for the 8-bit multi-cycle microcontroller datapath. It is the steering counterpart of the 2:1 datapath selector.
- Routes one 8-bit producer stream to one of two consumers, selected per transfer.
- Each destination has a one-entry holding register with a valid/ready handshake and a per-destination transfer counter.
- Sits between the ALU/result bus and two destination units, e.g. accumulator write-back and output port.

Parameters:
- WIDTH, 8, data width of input and both outputs.
- CNT_W, 8, width of each per-destination transfer counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  data from the producer.
- in_sel  input  1  destination select: 0 -> out1, 1 -> out2.
- in_valid  input  1  producer has data this cycle.
- in_ready  output  1  demux accepts in_data this cycle.
- out1_data  output  WIDTH  held data for destination 1.
- out1_valid  output  1  out1_data is valid.
- out1_ready  input  1  destination 1 consumes this cycle.
- out2_data  output  WIDTH  held data for destination 2.
- out2_valid  output  1  out2_data is valid.
- out2_ready  input  1  destination 2 consumes this cycle.
- out1_count  output  CNT_W  number of completed out1 handshakes.
- out2_count  output  CNT_W  number of completed out2 handshakes.

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous and active-high.
- Reset values: out1_data, out2_data, out1_count, out2_count all 0; out1_valid and out2_valid 0. in_ready is combinational, so it is 1 after reset.
- in_ready (combinational) = !outN_valid || outN_ready, where N is the port chosen by in_sel. It does not depend on the non-selected port.
- Input transfer occurs on in_valid && in_ready at a rising edge. in_data is registered into the selected slot and that slot's valid is set. Latency is 1 cycle: data is visible on outN_data the cycle after acceptance.
- Output transfer occurs on outN_valid && outN_ready at a rising edge. Valid clears unless a new write to the same slot happens in that cycle. outN_count increments by 1.
- Simultaneous consume and write on the same slot: valid stays 1, data takes the new value, count increments. This gives a sustained throughput of one transfer per cycle per slot.
- Simultaneous write to slot A and consume from slot B: both take effect independently.
- Hold rule: while outN_valid && !outN_ready, outN_data and outN_valid are stable, and further writes to slot N stall (in_ready = 0 for that selection).
- Counters wrap modulo 2^CNT_W (255 + 1 -> 0). They count output handshakes, not input acceptances.
- outN_data keeps its last value after valid drops; it is not cleared.
- in_data and in_sel are don't-care when in_valid = 0. No state changes without a handshake.
- Reset mid-operation: all pending data is discarded, valids and counters return to 0 immediately (asynchronous). The first accept is possible on the first edge after rst deasserts.
- No state machine beyond a per-slot EMPTY (valid = 0) / FULL (valid = 1) bit:
  - EMPTY -> FULL on write.
  - FULL -> EMPTY on consume without a write.
  - FULL -> FULL on write+consume, or when idle.

Decomposition:
- Shared package: WIDTH_DEFAULT = 8, CNT_W_DEFAULT = 8, SEL_OUT1 = 1'b0, SEL_OUT2 = 1'b1. The select encoding is shared with the datapath selector so that sel = 0 means path 1 everywhere.
- Sub-module demux_slot: one holding register, valid bit, transfer counter, and ready computation. Instantiated twice.
- Top level: select decode, write-enable generation, and in_ready muxing.

Test Plan:
1. Reset, then in_valid = 1, in_sel = 0, in_data = 8'hA5 for one cycle with out1_ready = 0 -> next cycle out1_valid = 1, out1_data = A5, out2_valid = 0. in_ready = 0 for sel = 0 and 1 for sel = 1.
2. Slot 1 holding A5 with out1_ready = 0; drive sel = 0, data = 3C for 3 cycles -> in_ready = 0 and out1_data stays A5. Raise out1_ready -> same-edge write accepted, out1_data = 3C, out1_count = 1.
3. Back-to-back sel = 1, data 01, 02, 03, 04 with out2_ready held 1 -> in_ready is 1 every cycle, out2_data sequence 01..04 one cycle late, out2_count = 4, out2_valid drops the cycle after the last.
4. Slot 1 full and stalled; present sel = 1, data = 77 -> accepted, out2_data = 77, out1 unchanged.
5. 256 consumes on out1 -> out1_count goes 255 -> 0.
6. Both slots full; assert rst asynchronously mid-cycle -> valids and counts 0 before the next edge, in_ready = 1. After release, a write of 5A to out2 works normally.

Source files
------------

// File: rtl/demux_buf_pkg.sv
// Shared constants for the demux_buf steering block. The select encoding
// matches the 2:1 datapath selector so that sel = 0 means path 1 everywhere.
package demux_buf_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int CNT_W_DEFAULT = 8;

  localparam logic SEL_OUT1 = 1'b0;
  localparam logic SEL_OUT2 = 1'b1;

endpackage : demux_buf_pkg

// File: rtl/demux_buf_slot.sv
// One destination of the demultiplexer: a one-entry holding register with
// a valid flag (EMPTY/FULL), a handshake counter and the ready term that
// tells the producer side whether this slot can take a write this cycle.
module demux_slot
  import demux_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic             wr_ready
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             consume;

  // Next-state: a write always refills the slot, a consume without a write
  // empties it, and every consume is counted (wrapping naturally).
  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q;
    count_d  = count_q;
    consume  = valid_q && rd_ready;
    wr_ready = !valid_q || rd_ready;
    if (consume) begin
      valid_d = 1'b0;
      count_d = count_q + 1'b1;
    end
    if (wr_en) begin
      valid_d = 1'b1;
      data_d  = wr_data;
    end
  end

  // Slot state register; reset discards any pending entry at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign count = count_q;

endmodule : demux_slot

// File: rtl/demux_buf.sv
// 1:2 buffered demultiplexer: steers one producer stream into one of two
// holding slots chosen per transfer by in_sel, each with its own handshake.
module demux_buf
  import demux_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [CNT_W-1:0] out1_count,
  output logic [CNT_W-1:0] out2_count
);

  logic slot1_ready;
  logic slot2_ready;
  logic wr_en1;
  logic wr_en2;
  logic accept;

  // Ready follows only the selected slot; the write enable goes to that slot
  // alone so the other destination can drain independently.
  always_comb begin
    in_ready = (in_sel == SEL_OUT2) ? slot2_ready : slot1_ready;
    accept   = in_valid && in_ready;
    wr_en1   = accept && (in_sel == SEL_OUT1);
    wr_en2   = accept && (in_sel == SEL_OUT2);
  end

  demux_slot #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_slot1 (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en1),
    .wr_data  (in_data),
    .rd_ready (out1_ready),
    .data     (out1_data),
    .valid    (out1_valid),
    .count    (out1_count),
    .wr_ready (slot1_ready)
  );

  demux_slot #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_slot2 (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en2),
    .wr_data  (in_data),
    .rd_ready (out2_ready),
    .data     (out2_data),
    .valid    (out2_valid),
    .count    (out2_count),
    .wr_ready (slot2_ready)
  );

endmodule : demux_buf

// File: tb/tb_demux_buf.sv
// Bench for demux_buf: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a slot-array model.
module tb_demux_buf;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out1_data;
  logic       out1_valid;
  logic       out1_ready;
  logic [7:0] out2_data;
  logic       out2_valid;
  logic       out2_ready;
  logic [7:0] out1_count;
  logic [7:0] out2_count;

  int tests_run;
  int tests_failed;

  // Behavioural model: index 0 is out1, index 1 is out2.
  int m_valid [2];
  int m_data  [2];
  int m_count [2];

  demux_buf dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out2_data  (out2_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .out1_count (out1_count),
    .out2_count (out2_count)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int model_ready(input int sel);
    int rdy;
    rdy = (sel == 1) ? int'(out2_ready) : int'(out1_ready);
    return (m_valid[sel] == 0 || rdy != 0) ? 1 : 0;
  endfunction

  // Model update: what each slot holds after this edge, from the handshake rules.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 2; n++) begin
        m_valid[n] = 0;
        m_data[n]  = 0;
        m_count[n] = 0;
      end
    end else begin
      int sel;
      int acc;
      int rdy [2];
      sel    = int'(in_sel);
      acc    = (in_valid && model_ready(sel) != 0) ? 1 : 0;
      rdy[0] = int'(out1_ready);
      rdy[1] = int'(out2_ready);
      for (int n = 0; n < 2; n++) begin
        if (m_valid[n] != 0 && rdy[n] != 0) begin
          m_count[n] = (m_count[n] + 1) % 256;
          m_valid[n] = 0;
        end
        if (acc != 0 && sel == n) begin
          m_valid[n] = 1;
          m_data[n]  = int'(in_data);
        end
      end
    end
  end

  // Compare process: every cycle outside reset, DUT outputs versus the model.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("in_ready",   int'(in_ready),   model_ready(int'(in_sel)));
      checkOutput("out1_valid", int'(out1_valid), m_valid[0]);
      checkOutput("out1_data",  int'(out1_data),  m_data[0]);
      checkOutput("out1_count", int'(out1_count), m_count[0]);
      checkOutput("out2_valid", int'(out2_valid), m_valid[1]);
      checkOutput("out2_data",  int'(out2_data),  m_data[1]);
      checkOutput("out2_count", int'(out2_count), m_count[1]);
    end
  end

  task automatic applyStimulus(input logic v, input logic s, input logic [7:0] d,
                               input logic r1, input logic r2);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out1_ready = r1;
    out2_ready = r2;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    checkOutput("reset_out1_valid", int'(out1_valid), 0);
    checkOutput("reset_out2_count", int'(out2_count), 0);
    checkOutput("reset_in_ready",   int'(in_ready),   1);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Scenario 1: single write to out1, destination stalled.
    applyStimulus(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
    tick();
    checkOutput("s1_out1_valid", int'(out1_valid), 1);
    checkOutput("s1_out1_data",  int'(out1_data),  8'hA5);
    checkOutput("s1_out2_valid", int'(out2_valid), 0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1 checkOutput("s1_ready_sel0", int'(in_ready), 0);
    in_sel = 1'b1;
    #1 checkOutput("s1_ready_sel1", int'(in_ready), 1);
    tick();

    // Scenario 2: write to the stalled slot waits, then goes in on release.
    applyStimulus(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("s2_stall_ready", int'(in_ready), 0);
      checkOutput("s2_hold_data",   int'(out1_data), 8'hA5);
    end
    out1_ready = 1'b1;
    #1 checkOutput("s2_release_ready", int'(in_ready), 1);
    tick();
    checkOutput("s2_out1_data",  int'(out1_data),  8'h3C);
    checkOutput("s2_out1_valid", int'(out1_valid), 1);
    checkOutput("s2_out1_count", int'(out1_count), 1);

    // Scenario 3: back-to-back stream to out2 at full rate.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(i), 1'b0, 1'b1);
      #1 checkOutput("s3_ready", int'(in_ready), 1);
      tick();
      checkOutput("s3_out2_data", int'(out2_data), i);
    end
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("s3_out2_valid", int'(out2_valid), 0);
    checkOutput("s3_out2_count", int'(out2_count), 4);

    // Scenario 4: out1 stalled does not block a write to out2.
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
    #1 checkOutput("s4_ready", int'(in_ready), 1);
    tick();
    checkOutput("s4_out2_data",  int'(out2_data),  8'h77);
    checkOutput("s4_out1_data",  int'(out1_data),  8'h3C);
    checkOutput("s4_out1_valid", int'(out1_valid), 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Scenario 6: asynchronous reset mid-cycle with both slots full.
    rst = 1'b1;
    #1;
    checkOutput("s6_out1_valid", int'(out1_valid), 0);
    checkOutput("s6_out2_valid", int'(out2_valid), 0);
    checkOutput("s6_out1_count", int'(out1_count), 0);
    checkOutput("s6_out2_count", int'(out2_count), 0);
    checkOutput("s6_in_ready",   int'(in_ready),   1);
    #1 rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
    tick();
    checkOutput("s6_out2_data",  int'(out2_data),  8'h5A);
    checkOutput("s6_out2_valid", int'(out2_valid), 1);

    // Scenario 5: 256 consumes on out1 wrap its counter to zero.
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(i), 1'b1, 1'b0);
      tick();
    end
    checkOutput("s5_count_255", int'(out1_count), 255);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("s5_count_wrap", int'(out1_count), 0);
    checkOutput("s5_valid_drop", int'(out1_valid), 0);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
                    8'($urandom_range(0, 255)),
                    logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 1)));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_demux_buf
